// File: rtl/snake_pkg.sv
// Shared types and constants for the snake VGA demo: game states, head
// directions, LFSR seed and RGB565 palette.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam logic [15:0] RGB_BLACK = 16'h0000;
   localparam logic [15:0] RGB_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB_RED   = 16'hF800;
   localparam logic [15:0] RGB_GREEN = 16'h07E0;
   localparam logic [15:0] RGB_BLUE  = 16'h001F;

   // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
   function automatic dir_e opposite(input dir_e d);
      return dir_e'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the bit fields used
// to pick the next food cell.
module snake_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   output logic [6:0] cell_x_o,
   output logic [5:0] cell_y_o
);

   logic [15:0] lfsr_q;
   logic        fb;

   assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         lfsr_q <= SEED;
      else if (en_i)
         lfsr_q <= {lfsr_q[14:0], fb};
   end

   assign cell_x_o = lfsr_q[6:0];
   assign cell_y_o = lfsr_q[13:8];

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER control, frame-paced head stepping,
// wall collision and food pickup. All outputs are registered.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int H_DISP      = 800,
   parameter int V_DISP      = 600,
   parameter int BLOCK_W     = 10,
   parameter int STEP_FRAMES = 6,
   parameter int START_X     = 400,
   parameter int START_Y     = 300,
   parameter int FOOD_X0     = 200,
   parameter int FOOD_Y0     = 150
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       frame_start,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_start,
   output logic [9:0] box_x,
   output logic [9:0] box_y,
   output logic [9:0] food_x,
   output logic [9:0] food_y,
   output logic       fin,
   output logic [1:0] game_state,
   output logic [7:0] score
);

   localparam logic signed [10:0] STEP_S = 11'(BLOCK_W);
   localparam logic signed [10:0] X_MAX  = 11'(H_DISP - BLOCK_W);
   localparam logic signed [10:0] Y_MAX  = 11'(V_DISP - BLOCK_W);
   localparam logic [7:0]         LAST   = 8'(STEP_FRAMES - 1);

   state_e      state_q, state_d;
   dir_e        dir_q, dir_d, pend_q, pend_d;
   logic [7:0]  step_q, step_d;
   logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
   logic [9:0]  food_x_q, food_x_d, food_y_q, food_y_d;
   logic [7:0]  score_q, score_d;
   logic        fin_q, fin_d;
   logic        kstart_q;

   logic              start_edge, hit_wall, eat;
   logic signed [10:0] nx, ny;
   logic [6:0]        lfsr_x, cx;
   logic [5:0]        lfsr_y, cy;

   snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i    (vga_clk),
      .rst_i    (sys_rst),
      .en_i     (1'b1),
      .cell_x_o (lfsr_x),
      .cell_y_o (lfsr_y)
   );

   assign start_edge = key_start & ~kstart_q;
   assign cx = (lfsr_x >= 7'd80) ? lfsr_x - 7'd80 : lfsr_x;
   assign cy = (lfsr_y >= 6'd60) ? lfsr_y - 6'd60 : lfsr_y;

   // Candidate head position, one block along the pending direction.
   always_comb begin
      nx = $signed({1'b0, box_x_q});
      ny = $signed({1'b0, box_y_q});
      case (pend_q)
         DIR_UP:    ny = ny - STEP_S;
         DIR_DOWN:  ny = ny + STEP_S;
         DIR_LEFT:  nx = nx - STEP_S;
         default:   nx = nx + STEP_S;
      endcase
   end

   assign hit_wall = (nx < 11'sd0) || (nx > X_MAX) || (ny < 11'sd0) || (ny > Y_MAX);
   assign eat      = (nx[9:0] == food_x_q) && (ny[9:0] == food_y_q);

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      pend_d   = pend_q;
      step_d   = step_q;
      box_x_d  = box_x_q;
      box_y_d  = box_y_q;
      food_x_d = food_x_q;
      food_y_d = food_y_q;
      score_d  = score_q;
      fin_d    = fin_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_PLAY;
               box_x_d = 10'(START_X);
               box_y_d = 10'(START_Y);
               dir_d   = DIR_RIGHT;
               pend_d  = DIR_RIGHT;
               step_d  = '0;
               score_d = '0;
            end
         end
         ST_PLAY: begin
            // Reversal keys are dropped so a lower-priority key can still win.
            if (key_up && opposite(dir_q) != DIR_UP)
               pend_d = DIR_UP;
            else if (key_down && opposite(dir_q) != DIR_DOWN)
               pend_d = DIR_DOWN;
            else if (key_left && opposite(dir_q) != DIR_LEFT)
               pend_d = DIR_LEFT;
            else if (key_right && opposite(dir_q) != DIR_RIGHT)
               pend_d = DIR_RIGHT;
            if (frame_start) begin
               if (step_q == LAST) begin
                  step_d = '0;
                  dir_d  = pend_q;
                  if (hit_wall) begin
                     state_d = ST_OVER;
                     fin_d   = 1'b1;
                  end else begin
                     box_x_d = nx[9:0];
                     box_y_d = ny[9:0];
                     if (eat) begin
                        if (score_q != 8'hFF)
                           score_d = score_q + 8'd1;
                        food_x_d = 10'(cx * BLOCK_W);
                        food_y_d = 10'(cy * BLOCK_W);
                     end
                  end
               end else begin
                  step_d = step_q + 8'd1;
               end
            end
         end
         ST_OVER: begin
            if (start_edge) begin
               state_d = ST_IDLE;
               fin_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_RIGHT;
         pend_q   <= DIR_RIGHT;
         step_q   <= '0;
         box_x_q  <= 10'(START_X);
         box_y_q  <= 10'(START_Y);
         food_x_q <= 10'(FOOD_X0);
         food_y_q <= 10'(FOOD_Y0);
         score_q  <= '0;
         fin_q    <= 1'b0;
         kstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         step_q   <= step_d;
         box_x_q  <= box_x_d;
         box_y_q  <= box_y_d;
         food_x_q <= food_x_d;
         food_y_q <= food_y_d;
         score_q  <= score_d;
         fin_q    <= fin_d;
         kstart_q <= key_start;
      end
   end

   assign box_x      = box_x_q;
   assign box_y      = box_y_q;
   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign fin        = fin_q;
   assign game_state = state_q;
   assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed scoreboard bench for snake_game_ctrl: one default instance and one
// placed near the right wall with food in its path.
module tb_snake_game_ctrl;

   logic vga_clk = 1'b0;
   logic sys_rst = 1'b0;

   logic       fs[2], kup[2], kdn[2], klf[2], krt[2], kst[2];
   logic [9:0] bx[2], by[2], fx[2], fy[2];
   logic       fin[2];
   logic [1:0] gs[2];
   logic [7:0] sc[2];

   snake_game_ctrl u_a (
      .vga_clk     (vga_clk),
      .sys_rst     (sys_rst),
      .frame_start (fs[0]),
      .key_up      (kup[0]),
      .key_down    (kdn[0]),
      .key_left    (klf[0]),
      .key_right   (krt[0]),
      .key_start   (kst[0]),
      .box_x       (bx[0]),
      .box_y       (by[0]),
      .food_x      (fx[0]),
      .food_y      (fy[0]),
      .fin         (fin[0]),
      .game_state  (gs[0]),
      .score       (sc[0])
   );

   snake_game_ctrl #(
      .STEP_FRAMES (3),
      .START_X     (780),
      .START_Y     (300),
      .FOOD_X0     (790),
      .FOOD_Y0     (300)
   ) u_b (
      .vga_clk     (vga_clk),
      .sys_rst     (sys_rst),
      .frame_start (fs[1]),
      .key_up      (kup[1]),
      .key_down    (kdn[1]),
      .key_left    (klf[1]),
      .key_right   (krt[1]),
      .key_start   (kst[1]),
      .box_x       (bx[1]),
      .box_y       (by[1]),
      .food_x      (fx[1]),
      .food_y      (fy[1]),
      .fin         (fin[1]),
      .game_state  (gs[1]),
      .score       (sc[1])
   );

   always #5 vga_clk = ~vga_clk;

   // Reference LFSR: taps 16,14,13,11, seed ACE1, free-running.
   logic [15:0] lfsr_m;
   always @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst)
         lfsr_m <= 16'hACE1;
      else
         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   typedef struct {
      string       tag;
      int unsigned fld;
      int          val;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   function automatic int obs(int d, int unsigned f);
      case (f)
         0:       return int'(bx[d]);
         1:       return int'(by[d]);
         2:       return int'(fx[d]);
         3:       return int'(fy[d]);
         4:       return int'(fin[d]);
         5:       return int'(gs[d]);
         default: return int'(sc[d]);
      endcase
   endfunction

   function automatic int reloc_x(logic [15:0] l);
      int c = int'(l[6:0]);
      if (c >= 80) c = c - 80;
      return c * 10;
   endfunction

   function automatic int reloc_y(logic [15:0] l);
      int c = int'(l[13:8]);
      if (c >= 60) c = c - 60;
      return c * 10;
   endfunction

   task automatic push(string tag, int unsigned f, int v);
      exp_t e;
      e.tag = tag;
      e.fld = f;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic exp_all(string tag, int x, int y, int f_x, int f_y, int f, int st, int s);
      push({tag, ".box_x"}, 0, x);
      push({tag, ".box_y"}, 1, y);
      push({tag, ".food_x"}, 2, f_x);
      push({tag, ".food_y"}, 3, f_y);
      push({tag, ".fin"}, 4, f);
      push({tag, ".game_state"}, 5, st);
      push({tag, ".score"}, 6, s);
   endtask

   task automatic chk(int d);
      exp_t e;
      int   o;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obs(d, e.fld);
         total++;
         assert (o === e.val)
         else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", e.tag, o, e.val);
         end
      end
   endtask

   task automatic step_clk();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic frame(int d);
      fs[d] = 1'b1;
      step_clk();
      fs[d] = 1'b0;
      chk(d);
      step_clk();
   endtask

   task automatic start(int d);
      kst[d] = 1'b1;
      step_clk();
      kst[d] = 1'b0;
      chk(d);
      step_clk();
   endtask

   int ex, ey;

   initial begin
      for (int i = 0; i < 2; i++) begin
         fs[i] = 0; kup[i] = 0; kdn[i] = 0; klf[i] = 0; krt[i] = 0; kst[i] = 0;
      end
      #1 sys_rst = 1'b1;
      #2;
      exp_all("reset_a", 400, 300, 200, 150, 0, 0, 0); chk(0);
      exp_all("reset_b", 780, 300, 790, 300, 0, 0, 0); chk(1);
      step_clk(); step_clk();
      sys_rst = 1'b0;
      step_clk();

      exp_all("idle_frame", 400, 300, 200, 150, 0, 0, 0); frame(0);
      exp_all("start", 400, 300, 200, 150, 0, 1, 0); start(0);
      repeat (4) frame(0);
      exp_all("pre_step", 400, 300, 200, 150, 0, 1, 0); frame(0);
      exp_all("step1", 410, 300, 200, 150, 0, 1, 0); frame(0);

      klf[0] = 1'b1;
      repeat (5) frame(0);
      exp_all("left_ignored", 420, 300, 200, 150, 0, 1, 0); frame(0);
      klf[0] = 1'b0;

      kup[0] = 1'b1; step_clk(); kup[0] = 1'b0;
      repeat (5) frame(0);
      exp_all("turn_up", 420, 290, 200, 150, 0, 1, 0); frame(0);

      kdn[0] = 1'b1;
      repeat (5) frame(0);
      exp_all("down_ignored", 420, 280, 200, 150, 0, 1, 0); frame(0);
      kdn[0] = 1'b0;

      repeat (5) frame(0);
      klf[0] = 1'b1;
      exp_all("key_on_step", 420, 270, 200, 150, 0, 1, 0); frame(0);
      klf[0] = 1'b0;
      repeat (5) frame(0);
      exp_all("key_after_step", 410, 270, 200, 150, 0, 1, 0); frame(0);

      repeat (3) frame(0);
      sys_rst = 1'b1;
      #2;
      exp_all("mid_reset", 400, 300, 200, 150, 0, 0, 0); chk(0);
      step_clk();
      sys_rst = 1'b0;
      step_clk();

      kst[0] = 1'b1; fs[0] = 1'b1;
      step_clk();
      kst[0] = 1'b0; fs[0] = 1'b0;
      exp_all("start_and_frame", 400, 300, 200, 150, 0, 1, 0); chk(0);
      step_clk();
      repeat (4) frame(0);
      exp_all("cnt_from_zero", 400, 300, 200, 150, 0, 1, 0); frame(0);
      exp_all("cnt_step", 410, 300, 200, 150, 0, 1, 0); frame(0);

      exp_all("b_start", 780, 300, 790, 300, 0, 1, 0); start(1);
      frame(1);
      exp_all("b_pre_step", 780, 300, 790, 300, 0, 1, 0); frame(1);
      ex = reloc_x(lfsr_m);
      ey = reloc_y(lfsr_m);
      exp_all("b_eat_edge", 790, 300, ex, ey, 0, 1, 1); frame(1);
      repeat (2) frame(1);
      exp_all("b_wall", 790, 300, ex, ey, 1, 2, 1); frame(1);
      krt[1] = 1'b1;
      repeat (2) frame(1);
      exp_all("b_frozen", 790, 300, ex, ey, 1, 2, 1); frame(1);
      krt[1] = 1'b0;
      exp_all("b_over_idle", 790, 300, ex, ey, 0, 0, 1); start(1);
      exp_all("b_restart", 780, 300, ex, ey, 0, 1, 0); start(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-sequencing controller for the snake VGA demo. It owns the play/over state machine, steps the head block once every STEP_FRAMES frames in the latched direction, and detects wall collisions and food pickup. It drives the box position, food position and `fin` flag consumed by the pixel generator. All position updates land at frame start, so the pixel generator never sees a position change mid-frame.

## Interface
Parameters:
- H_DISP, 800: active width, pixels
- V_DISP, 600: active height, pixels
- BLOCK_W, 10: block edge and step size, pixels
- STEP_FRAMES, 6: frames per head step (≥1)
- START_X / START_Y, 400 / 300: head position on game start
- FOOD_X0 / FOOD_Y0, 200 / 150: food position after reset

Ports:
- vga_clk  in  1  pixel clock, all logic rising-edge
- sys_rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- key_up / key_down / key_left / key_right  in  1 each  synchronized, debounced levels
- key_start  in  1  synchronized level; action on rising edge
- box_x / box_y  out  10 each  head top-left pixel
- food_x / food_y  out  10 each  food top-left pixel
- fin  out  1  game over, high in OVER only
- game_state  out  2  0=IDLE, 1=PLAY, 2=OVER
- score  out  8  foods eaten, saturates at 255

## Operation
- Reset values: state IDLE; box = (START_X, START_Y); food = (FOOD_X0, FOOD_Y0); dir = RIGHT; pend_dir = RIGHT; step_cnt 0; score 0; fin 0; LFSR 16'hACE1; start-edge register 0.
- start_edge = key_start & ~key_start_d.
- IDLE: on start_edge → PLAY. On entry: box = START, dir = pend_dir = RIGHT, step_cnt 0, score 0.
- PLAY, direction: each cycle, pend_dir takes the first pressed key in priority up>down>left>right. A key is ignored if it is the opposite of dir, where dir is the direction of the last executed step. No key pressed: pend_dir holds.
- PLAY, stepping: each frame_start increments step_cnt. When step_cnt == STEP_FRAMES-1, step_cnt returns to 0 and a step executes:
  - dir ← pend_dir.
  - next = box ± BLOCK_W on one axis, computed in 11-bit signed.
  - next_x < 0, next_x > H_DISP-BLOCK_W (790), next_y < 0, or next_y > V_DISP-BLOCK_W (590): → OVER, fin ← 1, box unchanged.
  - Otherwise box ← next. If next == food: score ← score+1 (saturating), and food relocates.
- Collision is checked before food, so a step that game-overs never scores.
- Food relocation: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle in every state.
  - cx = lfsr[6:0], minus 80 if ≥80 (range 0..79).
  - cy = lfsr[13:8], minus 60 if ≥60 (range 0..59).
  - food = (cx·BLOCK_W, cy·BLOCK_W).
  - Food may land on the head; no re-roll.
- OVER: fin held 1; box, food and score frozen. On start_edge → IDLE, fin ← 0, and the score stays visible until the next start.
- Keys are ignored outside PLAY. frame_start is ignored outside PLAY.

## Timing
- All outputs registered. Step results (box, food, score, fin, game_state) are visible on the cycle after the frame_start that completes the count.
- First step occurs on the STEP_FRAMES-th frame_start after entering PLAY.
- start_edge → game_state change: 1 cycle.
- start_edge and frame_start in the same cycle in IDLE: start wins, no step, step_cnt 0.
- Key change in the same cycle as a step: the step uses the pend_dir registered before that cycle; the new key affects the next step.
- sys_rst asserted mid-game: immediate return to reset values, independent of vga_clk.

## Structure
- Shared package `snake_pkg`:
  - state encodings (IDLE/PLAY/OVER)
  - direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - opposite-direction function
  - RGB565 colour constants
- One sub-module, `snake_lfsr`: 16-bit LFSR with seed parameter and a free-running enable.
- FSM, step counter and position arithmetic stay in `snake_game_ctrl`.

## Test plan
- Reset → box (400,300), food (200,150), fin 0, score 0, game_state 0. Pulse key_start, then 6 frame_start pulses → box_x 410 one cycle after the 6th, game_state 1.
- In PLAY moving RIGHT, hold key_left → dir stays RIGHT, box_x advances by 10 per step. Press key_up → next step gives box_y 290.
- Set START_X 780, moving RIGHT: first step → 790. Second step → fin 1, game_state 2, box_x stays 790. Further frame_start pulses change nothing.
- Force food to (410,300) via LFSR seed or hierarchical force. After one step: score 1, food changes to a multiple of 10 within 0..790 / 0..590.
- key_start and frame_start together in IDLE → PLAY, step_cnt 0, no move. key_start rising in OVER → IDLE, fin 0, score retained.
- Assert sys_rst mid-step-count in PLAY → all outputs at reset values within the same cycle, without a vga_clk edge.
